// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the fetch state encoding.
package cpu_pkg;

   localparam int ADDR_W = 8;
   localparam int INST_W = 10;
   localparam int OPC_W  = 4;

   localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;
   localparam logic [OPC_W-1:0] OPC_BEQZ = 4'b0011;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      HALT_PEND = 2'd2,
      HALTED    = 2'd3
   } fetch_state_e;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
      return inst[INST_W-1 -: OPC_W];
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM address/data, decode valid/ready, branch redirect and control.
interface inst_fetch_unit_if
   import cpu_pkg::*;
();
   logic              start;
   logic [ADDR_W-1:0] inst_address;
   logic [INST_W-1:0] inst_out;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              halted;

   // The fetch unit drives the ROM address and the decode-side buffer.
   modport master (
      input  start, inst_out, inst_ready, branch_taken, branch_target,
      output inst_address, inst_valid, inst, inst_pc, halted
   );

   modport slave (
      output start, inst_out, inst_ready, branch_taken, branch_target,
      input  inst_address, inst_valid, inst, inst_pc, halted
   );
endinterface

// File: rtl/inst_fetch_unit_buffer.sv
// One-entry valid/ready holding register for the fetched word and its address.
module fetch_buffer
   import cpu_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              flush_i,
   input  logic              take_i,
   input  logic [INST_W-1:0] inst_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              valid_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o
);

   logic              valid_q, valid_d;
   logic [INST_W-1:0] inst_q,  inst_d;
   logic [ADDR_W-1:0] pc_q,    pc_d;

   // Flush beats load beats take; data only moves on load so it stays stable under back-pressure.
   always_comb begin
      valid_d = valid_q;
      inst_d  = inst_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         inst_d  = inst_i;
         pc_d    = pc_i;
      end else if (take_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         inst_q  <= inst_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign inst_o  = inst_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC and fetch FSM, reads the combinational ROM and feeds decode.
module inst_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [OPC_W-1:0]  HALT_OPC = OPC_HALT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   inst_fetch_unit_if.master fetch_io
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;

   logic buf_load, buf_flush, buf_take;
   logic buf_valid;
   logic take;

   assign take = buf_valid & fetch_io.inst_ready;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      halted_d  = halted_q;
      buf_load  = 1'b0;
      buf_flush = 1'b0;
      buf_take  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fetch_io.start) begin
               state_d = RUN;
               pc_d    = RESET_PC;
            end
         end
         RUN: begin
            buf_take = take;
            if (fetch_io.branch_taken) begin
               buf_flush = 1'b1;
               pc_d      = fetch_io.branch_target;
            end else if (!buf_valid || take) begin
               buf_load = 1'b1;
               // A halt word parks the PC on itself so nothing past it is fetched.
               if (opcode_of(fetch_io.inst_out) == HALT_OPC) begin
                  state_d = HALT_PEND;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         HALT_PEND: begin
            // A redirect from an older instruction cancels the pending halt.
            if (fetch_io.branch_taken) begin
               buf_flush = 1'b1;
               pc_d      = fetch_io.branch_target;
               state_d   = RUN;
            end else if (take) begin
               buf_take = 1'b1;
               halted_d = 1'b1;
               state_d  = HALTED;
            end
         end
         HALTED: begin
            if (fetch_io.start) begin
               pc_d     = RESET_PC;
               halted_d = 1'b0;
               state_d  = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   fetch_buffer u_buffer (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (buf_load),
      .flush_i (buf_flush),
      .take_i  (buf_take),
      .inst_i  (fetch_io.inst_out),
      .pc_i    (pc_q),
      .valid_o (buf_valid),
      .inst_o  (fetch_io.inst),
      .pc_o    (fetch_io.inst_pc)
   );

   assign fetch_io.inst_valid   = buf_valid;
   assign fetch_io.inst_address = pc_q;
   assign fetch_io.halted       = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run against an accepted-stream model.
module tb_inst_fetch_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [9:0] rom0 [0:255];
   logic [9:0] rom1 [0:255];

   inst_fetch_unit_if bus0();
   inst_fetch_unit_if bus1();

   inst_fetch_unit #(.RESET_PC(8'd0)) dut0 (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .fetch_io (bus0)
   );

   inst_fetch_unit #(.RESET_PC(8'd254)) dut1 (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .fetch_io (bus1)
   );

   assign bus0.inst_out = rom0[bus0.inst_address];
   assign bus1.inst_out = rom1[bus1.inst_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_plain_roms();
      for (int a = 0; a < 256; a++) begin
         rom0[a] = {4'h1, 6'(a)};
         rom1[a] = {4'h2, 6'(a ^ 63)};
      end
      rom0[4] = 10'b1111000000;
   endtask

   task automatic do_reset();
      bus0.start = 0; bus0.inst_ready = 0; bus0.branch_taken = 0; bus0.branch_target = 0;
      bus1.start = 0; bus1.inst_ready = 0; bus1.branch_taken = 0; bus1.branch_target = 0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic pulse_start0();
      bus0.start = 1'b1;
      step();
      bus0.start = 1'b0;
   endtask

   task automatic test_reset();
      fill_plain_roms();
      do_reset();
      checks += 6;
      if (bus0.inst_address !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus0.inst_address); end
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus0.inst_valid); end
      if (bus0.inst !== 10'd0) begin errors++; $display("FAIL reset_inst got %h want 0", bus0.inst); end
      if (bus0.inst_pc !== 8'd0) begin errors++; $display("FAIL reset_instpc got %0d want 0", bus0.inst_pc); end
      if (bus0.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus0.halted); end
      if (bus1.inst_address !== 8'd254) begin errors++; $display("FAIL reset_addr_254 got %0d want 254", bus1.inst_address); end
      // Idle unit must not fetch without Start, branch ignored.
      bus0.inst_ready = 1'b1; bus0.branch_taken = 1'b1; bus0.branch_target = 8'd7;
      step(); step();
      bus0.branch_taken = 1'b0;
      checks += 2;
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", bus0.inst_valid); end
      if (bus0.inst_address !== 8'd0) begin errors++; $display("FAIL idle_addr got %0d want 0", bus0.inst_address); end
      $display("reset: addr=%0d valid=%b halted=%b", bus0.inst_address, bus0.inst_valid, bus0.halted);
   endtask

   task automatic test_fetch_halt();
      fill_plain_roms();
      do_reset();
      pulse_start0();
      bus0.inst_ready = 1'b1;
      checks += 2;
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL start_cycle_valid got %b want 0", bus0.inst_valid); end
      if (bus0.inst_address !== 8'd0) begin errors++; $display("FAIL start_cycle_addr got %0d want 0", bus0.inst_address); end
      for (int k = 0; k < 5; k++) begin
         step();
         $display("fetch: pc=%0d inst=%h addr=%0d", bus0.inst_pc, bus0.inst, bus0.inst_address);
         checks += 4;
         if (bus0.inst_valid !== 1'b1) begin errors++; $display("FAIL seq_valid k=%0d got %b want 1", k, bus0.inst_valid); end
         if (bus0.inst_pc !== 8'(k)) begin errors++; $display("FAIL seq_instpc got %0d want %0d", bus0.inst_pc, k); end
         if (bus0.inst !== rom0[k]) begin errors++; $display("FAIL seq_inst k=%0d got %h want %h", k, bus0.inst, rom0[k]); end
         if (bus0.inst_address !== ((k == 4) ? 8'd4 : 8'(k + 1))) begin
            errors++; $display("FAIL seq_addr k=%0d got %0d", k, bus0.inst_address);
         end
      end
      step();
      checks += 3;
      if (bus0.halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", bus0.halted); end
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", bus0.inst_valid); end
      if (bus0.inst_address !== 8'd4) begin errors++; $display("FAIL halt_addr got %0d want 4", bus0.inst_address); end
      step(); step();
      checks += 2;
      if (bus0.inst_address !== 8'd4) begin errors++; $display("FAIL halted_addr_hold got %0d want 4", bus0.inst_address); end
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL halted_valid_hold got %b want 0", bus0.inst_valid); end
      $display("halt: halted=%b addr=%0d", bus0.halted, bus0.inst_address);
   endtask

   task automatic test_backpressure();
      fill_plain_roms();
      do_reset();
      pulse_start0();
      bus0.inst_ready = 1'b1;
      step(); step();
      bus0.inst_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         $display("stall: pc=%0d inst=%h addr=%0d", bus0.inst_pc, bus0.inst, bus0.inst_address);
         checks += 4;
         if (bus0.inst_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", bus0.inst_valid); end
         if (bus0.inst_pc !== 8'd1) begin errors++; $display("FAIL bp_instpc got %0d want 1", bus0.inst_pc); end
         if (bus0.inst !== rom0[1]) begin errors++; $display("FAIL bp_inst got %h want %h", bus0.inst, rom0[1]); end
         if (bus0.inst_address !== 8'd2) begin errors++; $display("FAIL bp_addr got %0d want 2", bus0.inst_address); end
      end
      bus0.inst_ready = 1'b1;
      step();
      checks += 2;
      if (bus0.inst_pc !== 8'd2) begin errors++; $display("FAIL bp_resume_instpc got %0d want 2", bus0.inst_pc); end
      if (bus0.inst !== rom0[2]) begin errors++; $display("FAIL bp_resume_inst got %h want %h", bus0.inst, rom0[2]); end
   endtask

   task automatic test_branch();
      fill_plain_roms();
      do_reset();
      pulse_start0();
      bus0.inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
      checks += 1;
      if (bus0.inst_pc !== 8'd3) begin errors++; $display("FAIL br_pre_instpc got %0d want 3", bus0.inst_pc); end
      bus0.branch_taken = 1'b1; bus0.branch_target = 8'd9;
      step();
      bus0.branch_taken = 1'b0;
      checks += 2;
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL br_flush_valid got %b want 0", bus0.inst_valid); end
      if (bus0.inst_address !== 8'd9) begin errors++; $display("FAIL br_addr got %0d want 9", bus0.inst_address); end
      step();
      $display("branch: pc=%0d inst=%h", bus0.inst_pc, bus0.inst);
      checks += 3;
      if (bus0.inst_valid !== 1'b1) begin errors++; $display("FAIL br_tgt_valid got %b want 1", bus0.inst_valid); end
      if (bus0.inst_pc !== 8'd9) begin errors++; $display("FAIL br_tgt_instpc got %0d want 9", bus0.inst_pc); end
      if (bus0.inst !== rom0[9]) begin errors++; $display("FAIL br_tgt_inst got %h want %h", bus0.inst, rom0[9]); end
   endtask

   task automatic test_halt_branch();
      fill_plain_roms();
      do_reset();
      pulse_start0();
      bus0.inst_ready = 1'b1;
      for (int k = 0; k < 5; k++) step();
      bus0.inst_ready = 1'b0;
      checks += 1;
      if (bus0.inst !== rom0[4]) begin errors++; $display("FAIL hb_halt_buffered got %h want %h", bus0.inst, rom0[4]); end
      bus0.branch_taken = 1'b1; bus0.branch_target = 8'd0;
      step();
      bus0.branch_taken = 1'b0;
      checks += 3;
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL hb_flush_valid got %b want 0", bus0.inst_valid); end
      if (bus0.halted !== 1'b0) begin errors++; $display("FAIL hb_halted got %b want 0", bus0.halted); end
      if (bus0.inst_address !== 8'd0) begin errors++; $display("FAIL hb_addr got %0d want 0", bus0.inst_address); end
      bus0.inst_ready = 1'b1;
      step();
      $display("halt-branch: pc=%0d valid=%b halted=%b", bus0.inst_pc, bus0.inst_valid, bus0.halted);
      checks += 3;
      if (bus0.inst_valid !== 1'b1) begin errors++; $display("FAIL hb_tgt_valid got %b want 1", bus0.inst_valid); end
      if (bus0.inst_pc !== 8'd0) begin errors++; $display("FAIL hb_tgt_instpc got %0d want 0", bus0.inst_pc); end
      if (bus0.halted !== 1'b0) begin errors++; $display("FAIL hb_still_halted got %b want 0", bus0.halted); end
   endtask

   task automatic test_wrap();
      logic [7:0] want;
      fill_plain_roms();
      do_reset();
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      bus1.inst_ready = 1'b1;
      want = 8'd254;
      for (int k = 0; k < 4; k++) begin
         step();
         $display("wrap: pc=%0d inst=%h", bus1.inst_pc, bus1.inst);
         checks += 2;
         if (bus1.inst_pc !== want) begin errors++; $display("FAIL wrap_instpc got %0d want %0d", bus1.inst_pc, want); end
         if (bus1.inst !== rom1[want]) begin errors++; $display("FAIL wrap_inst got %h want %h", bus1.inst, rom1[want]); end
         want = want + 8'd1;
      end
   endtask

   task automatic test_async_reset();
      fill_plain_roms();
      do_reset();
      pulse_start0();
      bus0.inst_ready = 1'b1;
      step(); step(); step();
      #2 rst_n = 1'b0;
      #1;
      checks += 3;
      if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", bus0.inst_valid); end
      if (bus0.inst_address !== 8'd0) begin errors++; $display("FAIL arst_addr got %0d want 0", bus0.inst_address); end
      if (bus0.halted !== 1'b0) begin errors++; $display("FAIL arst_halted got %b want 0", bus0.halted); end
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks += 2;
         if (bus0.inst_valid !== 1'b0) begin errors++; $display("FAIL arst_idle_valid got %b want 0", bus0.inst_valid); end
         if (bus0.inst_address !== 8'd0) begin errors++; $display("FAIL arst_idle_addr got %0d want 0", bus0.inst_address); end
      end
      pulse_start0();
      step();
      $display("arst restart: pc=%0d valid=%b", bus0.inst_pc, bus0.inst_valid);
      checks += 2;
      if (bus0.inst_valid !== 1'b1) begin errors++; $display("FAIL arst_restart_valid got %b want 1", bus0.inst_valid); end
      if (bus0.inst_pc !== 8'd0) begin errors++; $display("FAIL arst_restart_instpc got %0d want 0", bus0.inst_pc); end
   endtask

   // Model: decode sees a stream of (pc, rom[pc]); each accept advances pc by one,
   // a redirect replaces the next pc, and an accepted halt (without redirect) stops the stream.
   task automatic test_random();
      logic [7:0] exp_next, ipc, tgt;
      logic [9:0] ins, w;
      logic v, r, b;
      bit halt_acc, exp_halted;
      int halts, halt_at;
      for (int a = 0; a < 256; a++) begin
         w = 10'($urandom);
         if (w[9:6] == 4'hF) w[9:6] = 4'h3;
         rom0[a] = w;
      end
      halt_at = $urandom_range(10, 40);
      rom0[halt_at] = {4'hF, 6'($urandom)};
      do_reset();
      pulse_start0();
      exp_next = 8'd0; exp_halted = 0; halts = 0;
      for (int cyc = 0; cyc < 4000 && halts < 3; cyc++) begin
         bus0.inst_ready    = ($urandom_range(0, 3) != 0);
         b                  = ($urandom_range(0, 9) == 0);
         tgt                = 8'($urandom_range(0, 60));
         bus0.branch_taken  = b;
         bus0.branch_target = tgt;
         v = bus0.inst_valid; r = bus0.inst_ready; ipc = bus0.inst_pc; ins = bus0.inst;
         halt_acc = 0;
         if (v && r) begin
            $display("accept: pc=%0d inst=%h branch=%b", ipc, ins, b);
            checks += 2;
            if (ipc !== exp_next) begin errors++; $display("FAIL rnd_instpc got %0d want %0d", ipc, exp_next); end
            if (ins !== rom0[exp_next]) begin errors++; $display("FAIL rnd_inst got %h want %h", ins, rom0[exp_next]); end
            halt_acc = (ins[9:6] == 4'hF);
            exp_next = ipc + 8'd1;
         end
         if (b) exp_next = tgt;
         else if (halt_acc) exp_halted = 1;
         step();
         bus0.branch_taken = 1'b0;
         if (v && !r && !b) begin
            checks += 1;
            if (bus0.inst_valid !== 1'b1 || bus0.inst_pc !== ipc || bus0.inst !== ins) begin
               errors++;
               $display("FAIL rnd_stable got v=%b pc=%0d inst=%h want v=1 pc=%0d inst=%h",
                        bus0.inst_valid, bus0.inst_pc, bus0.inst, ipc, ins);
            end
         end
         checks += 1;
         if (exp_halted) begin
            if (bus0.halted !== 1'b1 || bus0.inst_valid !== 1'b0) begin
               errors++; $display("FAIL rnd_halted got h=%b v=%b want h=1 v=0", bus0.halted, bus0.inst_valid);
            end
            halts++;
            exp_halted = 0;
            pulse_start0();
            exp_next = 8'd0;
         end else if (bus0.halted !== 1'b0) begin
            errors++; $display("FAIL rnd_spurious_halt got %b want 0", bus0.halted);
         end
      end
      checks += 1;
      if (halts < 3) begin errors++; $display("FAIL rnd_timeout halts got %0d want 3", halts); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      test_reset();
      test_fetch_halt();
      test_backpressure();
      test_branch();
      test_halt_branch();
      test_wrap();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the 10-bit-instruction CPU. It drives the 8-bit instruction address to the combinational instruction ROM and registers the returned word into a one-entry output buffer.
- It hands instructions to decode with a valid/ready handshake.
- It owns the PC and handles branch redirect from execute.
- It predecodes the halt opcode so that fetching stops cleanly.

Parameters:
- ADDR_W, 8, instruction address width / PC width
- INST_W, 10, instruction word width
- OPC_W, 4, opcode field width (instruction bits [INST_W-1 -: OPC_W])
- HALT_OPC, 4'b1111, opcode that halts fetch
- RESET_PC, 0, PC value after reset and on Start

Ports:
- CLK  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; begins fetching from RESET_PC when IDLE or HALTED
- InstAddress  out  ADDR_W  address to instruction ROM; equals the PC register
- InstOut  in  INST_W  ROM data; combinational from InstAddress within the same cycle
- InstValid  out  1  output buffer holds a valid instruction
- Inst  out  INST_W  buffered instruction
- InstPC  out  ADDR_W  address Inst was fetched from
- InstReady  in  1  decode accepts Inst this cycle
- BranchTaken  in  1  execute redirect request
- BranchTarget  in  ADDR_W  absolute redirect address
- Halted  out  1  halt instruction has been consumed; fetch is stopped

Behaviour:
- All state is registered. Reset_n=0 asynchronously forces:
  - state=IDLE, PC=RESET_PC (so InstAddress=RESET_PC)
  - InstValid=0, Inst=0, InstPC=0, Halted=0
- States: IDLE, RUN, HALT_PEND, HALTED.
- Define take = InstValid & InstReady, and load = (!InstValid | take) & !BranchTaken.
- IDLE:
  - Start -> RUN; PC=RESET_PC. No fetch in the Start cycle.
  - BranchTaken is ignored.
- RUN, per clock edge, in priority order:
  - BranchTaken=1: InstValid<=0 (the buffer is flushed even if take=1 in the same cycle; that instruction counts as consumed). PC<=BranchTarget. State stays RUN. The first target instruction appears with InstValid=1 one cycle later.
  - load=1: Inst<=InstOut, InstPC<=PC, InstValid<=1.
    - If InstOut opcode == HALT_OPC: PC holds and state -> HALT_PEND.
    - Otherwise PC<=PC+1 modulo 2^ADDR_W (255 -> 0 wraps silently).
  - Otherwise (buffer full and not taken): PC, Inst and InstPC hold. InstOut is re-sampled later; the ROM is stateless.
- Fetch latency: address presented in cycle N -> InstValid=1 with that word in cycle N+1.
- Throughput: 1 instruction/cycle while InstReady=1.
- HALT_PEND:
  - No new fetch; PC holds at the halt address.
  - take=1 -> InstValid<=0, Halted<=1, state -> HALTED.
  - BranchTaken=1 (from an older instruction) -> flush, PC<=BranchTarget, state -> RUN, Halted stays 0. This takes priority over take.
- HALTED:
  - Halted=1, InstValid=0. BranchTaken is ignored.
  - Start -> PC=RESET_PC, Halted<=0, state -> RUN.
- Start in RUN or HALT_PEND is ignored.
- Inst and InstPC must not change while InstValid=1 and InstReady=0 (stable under back-pressure).
- Reset asserted mid-operation: immediate return to reset values, with no partial fetch completing. After release the unit waits in IDLE for Start.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, INST_W, OPC_W
  - OPC_HALT=4'b1111, OPC_BEQZ=4'b0011
  - fetch state enum (IDLE=2'd0, RUN=2'd1, HALT_PEND=2'd2, HALTED=2'd3)
- One natural sub-module: fetch_buffer, the one-entry valid/ready register holding Inst/InstPC with load/flush/take controls.
- PC and FSM stay in the top.

Test Plan:
- Reset, Start, InstReady=1, bench ROM with addr0..3 non-halt words and addr4=10'b1111000000: InstAddress steps 0,1,2,3,4. InstValid rises 1 cycle after Start+1. InstPC sequence 0..4. Halted=1 one cycle after the halt word is taken. InstAddress then stays 4.
- Back-pressure: InstReady=0 for 3 cycles while holding addr1 word. Inst and InstPC=1 are stable, PC stays 2. On InstReady=1, InstPC=2 follows next cycle with no skip or duplicate.
- Branch: BranchTaken=1, BranchTarget=8'd9 while InstPC=3 and InstReady=1. The next cycle has InstValid=0 and InstAddress=9. The following cycle has InstPC=9.
- Wrap: Start with RESET_PC=8'd254 and non-halt ROM. InstPC sequence is 254,255,0,1.
- Branch in HALT_PEND: the halt word is buffered at 4, InstReady=0, BranchTaken=1 with target 0. State returns to RUN, Halted stays 0, InstPC=0 next.
- Async reset: drop Reset_n mid-stream between clock edges. InstValid=0, InstAddress=RESET_PC and Halted=0 immediately. There is no fetch until Start.
